step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 24, log2 of auto-step period in clock cycles (range 2..31).
REQ-002 Parameter SCAN_DIV, default 16, log2 of display digit dwell in clock cycles (range 2..TICK_DIV).
REQ-003 clock  in  1  single system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 trigger  in  1  async pushbutton; rising edge requests one step in current mode.
REQ-006 toggle  in  1  async pushbutton; rising edge flips mode, then requests one step in new mode.
REQ-007 run  in  1  level; 1 = auto-step once per tick.
REQ-008 switchbit  in  1  width select; 1 = 4-bit datapath, 0 = 16-bit datapath.
REQ-009 dp_value  in  16  current datapath register value (4-bit mode uses [3:0]).
REQ-010 step  out  1  one-cycle pulse; datapath advances in mode.
REQ-011 mode  out  1  0 = counter (increment), 1 = LFSR shift.
REQ-012 width_sel  out  1  registered, synchronized copy of switchbit.
REQ-013 clear  out  1  one-cycle pulse; datapath loads zero.
REQ-014 seed  out  1  one-cycle pulse; datapath loads 16'h0001 (guard only).
REQ-015 led1, led2  out  1 each  led1 = counter mode, led2 = LFSR mode.
REQ-016 an  out  4  active-low one-hot digit enable.
REQ-017 digit  out  4  nibble for seven-segment decoder.
REQ-018 busy  out  1  high while FSM not in IDLE.

Function
REQ-019 trigger, toggle, switchbit SHALL each pass a 2-flop synchronizer; trigger/toggle events are synchronized 0->1 transitions.
REQ-020 FSM states SHALL be IDLE, MODE, STEP, CLEAR; all other encodings SHALL return to IDLE.
REQ-021 IDLE: width change -> CLEAR; else toggle event -> MODE; else trigger event or tick with run=1 -> STEP; else stay.
REQ-022 Priority in one cycle SHALL be width change > toggle > trigger > tick; lower-priority events in that cycle are dropped, not queued.
REQ-023 MODE SHALL invert mode, then go to STEP next cycle (step issued in new mode, 2 cycles after event registered).
REQ-024 STEP SHALL assert step for exactly one cycle, then IDLE.
REQ-025 CLEAR SHALL assert clear for one cycle, force mode=0, update width_sel, then IDLE.
REQ-026 Events arriving while busy=1 SHALL be dropped.
REQ-027 Tick SHALL be a one-cycle strobe from a free-running TICK_DIV-bit counter at wrap-around (all ones -> zero); counter runs regardless of run.
REQ-028 led1 = ~mode, led2 = mode, both registered.
REQ-029 width_sel=0: an SHALL rotate 1110->1101->1011->0111->1110 once per 2^SCAN_DIV cycles; digit = dp_value nibble 0,1,2,3 respectively.
REQ-030 width_sel=1: an SHALL be fixed 1110, digit = dp_value[3:0]; on return to 16-bit, scan restarts at 1110.
REQ-031 step, clear, seed SHALL be mutually exclusive in every cycle.

Reset
REQ-032 reset low SHALL immediately force: FSM IDLE, mode=0, step=0, clear=0, seed=0, led1=1, led2=0, an=1110, digit=0, busy=0, tick and scan counters 0, synchronizers 0, width_sel=0.
REQ-033 reset asserted mid-operation SHALL abort any pending pulse; no step/clear/seed after release until a new event.
REQ-034 First cycle after reset release SHALL not generate an event from inputs already high (synchronizers start at 0 but edge detect suppressed for 2 cycles).

Configuration
REQ-035 Macro SEQ_ZERO_GUARD_EN defined: in STEP with mode=1 and active-width dp_value all zero, SHALL assert seed instead of step (LFSR lock-up recovery).
REQ-036 SEQ_ZERO_GUARD_EN undefined: seed tied 0; STEP always asserts step.

Verification
REQ-037 Reset release, trigger pulse, dp_value=16'h0000, mode=0 -> single step pulse 3-4 cycles after trigger rise, led1=1, led2=0.
REQ-038 toggle pulse from mode=0 -> mode=1 one cycle, step next cycle, led2=1; second toggle -> mode=0 with step.
REQ-039 trigger and toggle rise same cycle -> exactly one MODE then one STEP; no second step.
REQ-040 TICK_DIV=4, run=1 -> step every 16 cycles; run=0 -> no step for 64 cycles.
REQ-041 dp_value=16'hABCD, width_sel=0, SCAN_DIV=2 -> (an,digit) = (1110,D),(1101,C),(1011,B),(0111,A) each 4 cycles; switchbit->1 -> clear pulse, mode=0, an=1110, digit=D.
REQ-042 SEQ_ZERO_GUARD_EN, mode=1, dp_value=0, trigger -> seed pulse, no step; without macro -> step pulse.

Source files
------------

// File: rtl/step_sequencer_if.sv
// Bundles the step sequencer's pushbutton, datapath and display signals.
// master: drives the buttons and the datapath value and watches the outputs.
// slave: the sequencer side of the same signals.
interface step_sequencer_if;
  logic        trigger;
  logic        toggle;
  logic        run;
  logic        switchbit;
  logic [15:0] dp_value;
  logic        step;
  logic        mode;
  logic        width_sel;
  logic        clear;
  logic        seed;
  logic        led1;
  logic        led2;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        busy;

  modport master (
    output trigger, toggle, run, switchbit, dp_value,
    input  step, mode, width_sel, clear, seed, led1, led2, an, digit, busy
  );

  modport slave (
    input  trigger, toggle, run, switchbit, dp_value,
    output step, mode, width_sel, clear, seed, led1, led2, an, digit, busy
  );
endinterface

// File: rtl/step_sequencer.sv
// Step sequencer: turns pushbutton edges and a periodic tick into single-cycle
// step/clear/seed pulses for a counter/LFSR datapath, and drives a 4-digit
// multiplexed seven-segment display of the datapath value.
// Optional feature: define SEQ_ZERO_GUARD_EN so that a step in LFSR mode with
// an all-zero active datapath issues seed instead of step (lock-up recovery).
module step_sequencer #(
  parameter int TICK_DIV = 24,
  parameter int SCAN_DIV = 16
) (
  input logic             clock,
  input logic             reset,
  step_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MODE  = 2'd1,
    STEP  = 2'd2,
    CLEAR = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [1:0] trigSync_q, toggleSync_q, widthSync_q;
  logic       trigPrev_q, togglePrev_q;
  logic [1:0] armCnt_q;
  logic       armed;
  logic       trigEvent, toggleEvent, widthChange, tick;

  logic [TICK_DIV-1:0] tickCnt_q;
  logic [SCAN_DIV-1:0] scanCnt_q, scanCnt_d;
  logic [1:0]          digitSel_q, digitSel_d;

  logic       mode_q, mode_d;
  logic       widthSel_q, widthSel_d;
  logic       led1_q, led2_q;
  logic [3:0] an_q, an_d;
  logic [3:0] digit_q, digit_d;
  logic       stepPulse, clearPulse, seedPulse;

`ifdef SEQ_ZERO_GUARD_EN
  logic activeZero;
  assign activeZero = widthSel_q ? (bus.dp_value[3:0] == 4'h0) : (bus.dp_value == 16'h0000);
`endif

  // Two-flop synchronizers, edge history, and a hold-off so inputs already high at reset release never count as edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trigSync_q   <= 2'b00;
      toggleSync_q <= 2'b00;
      widthSync_q  <= 2'b00;
      trigPrev_q   <= 1'b0;
      togglePrev_q <= 1'b0;
      armCnt_q     <= 2'd0;
    end else begin
      trigSync_q   <= {trigSync_q[0], bus.trigger};
      toggleSync_q <= {toggleSync_q[0], bus.toggle};
      widthSync_q  <= {widthSync_q[0], bus.switchbit};
      trigPrev_q   <= trigSync_q[1];
      togglePrev_q <= toggleSync_q[1];
      if (armCnt_q != 2'd3) armCnt_q <= armCnt_q + 2'd1;
    end
  end

  // Edge history is only trustworthy once the synchronizer pipeline has filled
  assign armed       = (armCnt_q == 2'd3);
  assign trigEvent   = armed & trigSync_q[1] & ~trigPrev_q;
  assign toggleEvent = armed & toggleSync_q[1] & ~togglePrev_q;
  assign widthChange = armed & (widthSync_q[1] != widthSel_q);
  assign tick        = &tickCnt_q;

  // Free-running tick counter; the tick strobe marks its all-ones to zero wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tickCnt_q <= '0;
    else        tickCnt_q <= tickCnt_q + TICK_DIV'(1);
  end

  // Next state, mode/width updates and the mutually exclusive output pulses
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    widthSel_d = widthSel_q;
    stepPulse  = 1'b0;
    clearPulse = 1'b0;
    seedPulse  = 1'b0;
    case (state_q)
      IDLE: begin
        if (widthChange) begin
          state_d    = CLEAR;
          mode_d     = 1'b0;
          widthSel_d = widthSync_q[1];
        end else if (toggleEvent) begin
          state_d = MODE;
          mode_d  = ~mode_q;
        end else if (trigEvent || (tick && bus.run)) begin
          state_d = STEP;
        end
      end
      MODE: state_d = STEP;
      STEP: begin
        state_d = IDLE;
`ifdef SEQ_ZERO_GUARD_EN
        if (mode_q && activeZero) seedPulse = 1'b1;
        else                      stepPulse = 1'b1;
`else
        stepPulse = 1'b1;
`endif
      end
      CLEAR: begin
        state_d    = IDLE;
        clearPulse = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register: FSM state, datapath mode, width selection, LEDs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      widthSel_q <= 1'b0;
      led1_q     <= 1'b1;
      led2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      widthSel_q <= widthSel_d;
      led1_q     <= ~mode_d;
      led2_q     <= mode_d;
    end
  end

  // Digit scan: rotate through four nibbles in 16-bit mode, park on digit 0 in 4-bit mode
  always_comb begin
    scanCnt_d  = scanCnt_q + SCAN_DIV'(1);
    digitSel_d = digitSel_q;
    if (widthSel_d) begin
      scanCnt_d  = '0;
      digitSel_d = 2'd0;
    end else if (&scanCnt_q) begin
      digitSel_d = digitSel_q + 2'd1;
    end
    an_d    = ~(4'b0001 << digitSel_d);
    digit_d = bus.dp_value[{digitSel_d, 2'b00} +: 4];
  end

  // Display registers so anode and digit change together and glitch-free
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scanCnt_q  <= '0;
      digitSel_q <= 2'd0;
      an_q       <= 4'b1110;
      digit_q    <= 4'h0;
    end else begin
      scanCnt_q  <= scanCnt_d;
      digitSel_q <= digitSel_d;
      an_q       <= an_d;
      digit_q    <= digit_d;
    end
  end

  assign bus.step      = stepPulse;
  assign bus.clear     = clearPulse;
  assign bus.seed      = seedPulse;
  assign bus.mode      = mode_q;
  assign bus.width_sel = widthSel_q;
  assign bus.led1      = led1_q;
  assign bus.led2      = led2_q;
  assign bus.an        = an_q;
  assign bus.digit     = digit_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed checks of reset, latency, priority,
// tick and display scan, then randomized button/width actions scored against
// an action-level model of mode, width and expected pulse counts.
module tb_step_sequencer;
  localparam int TDIV = 4;
  localparam int SDIV = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  int stepCnt = 0;
  int clearCnt = 0;
  int seedCnt = 0;
  int exclViol = 0;
  int cyc;
  int stepTimes[$];

  bit       mMode;
  bit       mWidth;
  bit       mSw;
  bit [15:0] mDp;

  step_sequencer_if bus ();

  step_sequencer #(.TICK_DIV(TDIV), .SCAN_DIV(SDIV)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Cycle count since the last reset release
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Pulse monitor sampled on the falling edge
  always @(negedge clock) begin
    if (reset) begin
      if (bus.step) begin
        stepCnt++;
        stepTimes.push_back(cyc);
      end
      if (bus.clear) clearCnt++;
      if (bus.seed)  seedCnt++;
      if ((int'(bus.step) + int'(bus.clear) + int'(bus.seed)) > 1) exclViol++;
    end
  end

  // Hard stop if something hangs
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    waitCycles(3);
    reset = 1'b1;
  endtask

  function automatic bit expectSeed(input bit md, input bit wd, input bit [15:0] dp);
    bit zero;
    zero = wd ? (dp[3:0] == 4'h0) : (dp == 16'h0000);
`ifdef SEQ_ZERO_GUARD_EN
    return md && zero;
`else
    return 1'b0;
`endif
  endfunction

  // One randomized action: 0 trigger, 1 toggle, 2 both, 3 width flip
  task automatic applyStimulus(input int kind);
    if (kind == 3) begin
      bus.switchbit = mSw;
      waitCycles(13);
    end else begin
      bus.trigger = (kind == 0 || kind == 2);
      bus.toggle  = (kind == 1 || kind == 2);
      waitCycles(3);
      bus.trigger = 1'b0;
      bus.toggle  = 1'b0;
      waitCycles(10);
    end
  endtask

  initial begin
    int s0, c0, d0, lat, sel, kind;
    bit expSeedB, expClear;
    logic [3:0] expAn;
    logic [15:0] nib;

    bus.trigger = 1'b0; bus.toggle = 1'b0; bus.run = 1'b0;
    bus.switchbit = 1'b0; bus.dp_value = 16'h1234;

    // Reset values, with trigger already high across release
    reset = 1'b0;
    bus.trigger = 1'b1;
    waitCycles(3);
    checkOutput("rst_step", bus.step, 1'b0);
    checkOutput("rst_clear", bus.clear, 1'b0);
    checkOutput("rst_seed", bus.seed, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_mode", bus.mode, 1'b0);
    checkOutput("rst_led1", bus.led1, 1'b1);
    checkOutput("rst_led2", bus.led2, 1'b0);
    checkOutput("rst_an", bus.an, 4'b1110);
    checkOutput("rst_digit", bus.digit, 4'h0);
    checkOutput("rst_wsel", bus.width_sel, 1'b0);
    reset = 1'b1;
    waitCycles(10);
    checkOutput("prehigh_nostep", stepCnt, 0);
    bus.trigger = 1'b0;
    waitCycles(4);

    // Trigger latency, mode 0, datapath zero
    bus.dp_value = 16'h0000;
    s0 = stepCnt;
    bus.trigger = 1'b1;
    lat = 0;
    while (stepCnt == s0 && lat < 10) begin
      waitCycles(1);
      lat++;
    end
    checkOutput("trig_latency_ok", (lat >= 3 && lat <= 4), 1'b1);
    checkOutput("trig_led1", bus.led1, 1'b1);
    checkOutput("trig_led2", bus.led2, 1'b0);
    bus.trigger = 1'b0;
    waitCycles(6);
    checkOutput("trig_one_step", stepCnt - s0, 1);

    // Toggle into LFSR mode: mode for one cycle, then step
    bus.dp_value = 16'h0005;
    s0 = stepCnt;
    bus.toggle = 1'b1;
    lat = 0;
    while (bus.mode !== 1'b1 && lat < 10) begin
      waitCycles(1);
      lat++;
    end
    checkOutput("tog_mode1", bus.mode, 1'b1);
    checkOutput("tog_nostep_yet", bus.step, 1'b0);
    waitCycles(1);
    checkOutput("tog_step", bus.step, 1'b1);
    checkOutput("tog_led2", bus.led2, 1'b1);
    bus.toggle = 1'b0;
    waitCycles(6);
    bus.toggle = 1'b1;
    waitCycles(3);
    bus.toggle = 1'b0;
    waitCycles(6);
    checkOutput("tog2_mode0", bus.mode, 1'b0);
    checkOutput("tog2_steps", stepCnt - s0, 2);

    // Trigger and toggle together: a single mode change and a single step
    s0 = stepCnt;
    bus.trigger = 1'b1;
    bus.toggle  = 1'b1;
    waitCycles(3);
    bus.trigger = 1'b0;
    bus.toggle  = 1'b0;
    waitCycles(8);
    checkOutput("both_steps", stepCnt - s0, 1);
    checkOutput("both_mode", bus.mode, 1'b1);

    // Reset while a step is pending
    s0 = stepCnt;
    bus.trigger = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(1);
    checkOutput("midrst_busy", bus.busy, 1'b0);
    checkOutput("midrst_mode", bus.mode, 1'b0);
    reset = 1'b1;
    waitCycles(12);
    checkOutput("midrst_nostep", stepCnt - s0, 0);
    bus.trigger = 1'b0;
    waitCycles(4);

    // Auto-step with run
    bus.dp_value = 16'h0001;
    stepTimes.delete();
    bus.run = 1'b1;
    lat = 0;
    while (stepTimes.size() < 4 && lat < 80) begin
      waitCycles(1);
      lat++;
    end
    if (stepTimes.size() < 4) begin
      checkOutput("tick_count", stepTimes.size(), 4);
    end else begin
      checkOutput("tick_period1", stepTimes[1] - stepTimes[0], 16);
      checkOutput("tick_period2", stepTimes[2] - stepTimes[1], 16);
      checkOutput("tick_period3", stepTimes[3] - stepTimes[2], 16);
    end
    bus.run = 1'b0;
    waitCycles(4);
    s0 = stepCnt;
    waitCycles(64);
    checkOutput("run0_nostep", stepCnt - s0, 0);

    // Display scan from a fresh reset
    bus.dp_value = 16'hABCD;
    doReset();
    nib = 16'hABCD;
    for (int i = 0; i < 32; i++) begin
      waitCycles(1);
      sel   = (cyc >> SDIV) & 3;
      expAn = ~(4'b0001 << sel);
      checkOutput($sformatf("scan_an_%0d", i), bus.an, expAn);
      checkOutput($sformatf("scan_dig_%0d", i), bus.digit, (nib >> (4 * sel)) & 16'hF);
    end

    // Go to LFSR mode, then switch to 4-bit: clear forces counter mode
    bus.toggle = 1'b1;
    waitCycles(3);
    bus.toggle = 1'b0;
    waitCycles(6);
    checkOutput("pre_w_mode", bus.mode, 1'b1);
    c0 = clearCnt;
    bus.switchbit = 1'b1;
    lat = 0;
    while (clearCnt == c0 && lat < 10) begin
      waitCycles(1);
      lat++;
    end
    checkOutput("w4_clear", clearCnt - c0, 1);
    checkOutput("w4_mode", bus.mode, 1'b0);
    checkOutput("w4_wsel", bus.width_sel, 1'b1);
    waitCycles(8);
    checkOutput("w4_an", bus.an, 4'b1110);
    checkOutput("w4_digit", bus.digit, 4'hD);
    c0 = clearCnt;
    bus.switchbit = 1'b0;
    lat = 0;
    while (clearCnt == c0 && lat < 10) begin
      waitCycles(1);
      lat++;
    end
    checkOutput("w16_clear", clearCnt - c0, 1);
    checkOutput("w16_an_restart", bus.an, 4'b1110);
    checkOutput("w16_wsel", bus.width_sel, 1'b0);
    waitCycles(4);

    // Zero-guard: LFSR mode with zero datapath
    bus.toggle = 1'b1;
    waitCycles(3);
    bus.toggle = 1'b0;
    waitCycles(6);
    bus.dp_value = 16'h0000;
    s0 = stepCnt;
    d0 = seedCnt;
    bus.trigger = 1'b1;
    waitCycles(3);
    bus.trigger = 1'b0;
    waitCycles(6);
`ifdef SEQ_ZERO_GUARD_EN
    checkOutput("guard_seed", seedCnt - d0, 1);
    checkOutput("guard_nostep", stepCnt - s0, 0);
`else
    checkOutput("guard_seed", seedCnt - d0, 0);
    checkOutput("guard_step", stepCnt - s0, 1);
`endif

    // Randomized actions against the action-level model
    bus.dp_value = 16'h0000;
    bus.switchbit = 1'b0;
    doReset();
    waitCycles(4);
    mMode = 1'b0; mWidth = 1'b0; mSw = 1'b0;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       mDp = 16'h0000;
        1:       mDp = 16'($urandom) & 16'hFFF0;
        default: mDp = 16'($urandom);
      endcase
      bus.dp_value = mDp;
      expClear = 1'b0;
      expSeedB = 1'b0;
      if (kind == 3) begin
        mSw = ~mSw;
        mWidth = mSw;
        mMode = 1'b0;
        expClear = 1'b1;
      end else begin
        if (kind != 0) mMode = ~mMode;
        expSeedB = expectSeed(mMode, mWidth, mDp);
      end
      s0 = stepCnt; c0 = clearCnt; d0 = seedCnt;
      applyStimulus(kind);
      checkOutput($sformatf("rnd%0d_step", it), stepCnt - s0,
                  (kind == 3 || expSeedB) ? 0 : 1);
      checkOutput($sformatf("rnd%0d_seed", it), seedCnt - d0, expSeedB ? 1 : 0);
      checkOutput($sformatf("rnd%0d_clear", it), clearCnt - c0, expClear ? 1 : 0);
      checkOutput($sformatf("rnd%0d_mode", it), bus.mode, mMode);
      checkOutput($sformatf("rnd%0d_led2", it), bus.led2, mMode);
      checkOutput($sformatf("rnd%0d_wsel", it), bus.width_sel, mWidth);
    end

    checkOutput("exclusive", exclViol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
